// File: rtl/fe_dispatch_queue.sv
// ---------------------------------------------------------------------------
// fe_dispatch_queue
//
// Decoupling FIFO between the front end and the back-end dispatch/rename
// stage. Decoded instruction words are accepted from the front end, buffered
// (up to DEPTH_P entries) and presented in order to the dispatch stage.
// A mispredict flush empties the queue in a single cycle.
//
// Optional feature (compile-time macro): FE_QUEUE_BYPASS_EN
//   Defined   : an incoming word arriving at an empty queue is presented on
//               valid_o/data_o in the same cycle. If dispatch takes it in that
//               cycle, it is never written into storage.
//   Undefined : no combinational path from valid_i/data_i to valid_o/data_o;
//               minimum latency through the queue is one cycle.
//
// Parameters
//   DEPTH_P  number of entries (power of two, >= 2)
//   WIDTH_P  bits per entry (width of a decoded instruction word)
//
// Ports
//   clk_i        in   1                   clock, all state updates on posedge
//   reset_i      in   1                   synchronous reset, active low
//   mis_predict  in   1                   flush: drop all entries and this
//                                         cycle's enqueue
//   valid_i      in   1                   front-end word valid
//   data_i       in   WIDTH_P             front-end decoded instruction
//   ready_o      out  1                   queue can accept (to fe ready_i)
//   valid_o      out  1                   head entry valid to dispatch
//   data_o       out  WIDTH_P             head entry
//   ready_i      in   1                   dispatch consumes head this cycle
//   count_o      out  $clog2(DEPTH_P)+1   occupancy, 0..DEPTH_P
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high (valid_i/ready_o on the input side, valid_o/ready_i on the output
// side) and mis_predict is low. A producer holding valid high must keep its
// data stable until the transfer. ready_o depends only on registered state,
// never on valid_i or ready_i, so a full queue refuses a new word even in a
// cycle where the head is being consumed.
// ---------------------------------------------------------------------------
module fe_dispatch_queue #(
  parameter int DEPTH_P = 8,
  parameter int WIDTH_P = 64
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       mis_predict,
  input  logic                       valid_i,
  input  logic [WIDTH_P-1:0]         data_i,
  output logic                       ready_o,
  output logic                       valid_o,
  output logic [WIDTH_P-1:0]         data_o,
  input  logic                       ready_i,
  output logic [$clog2(DEPTH_P):0]   count_o
);

  localparam int AW = $clog2(DEPTH_P);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH_P);

  // Storage and pointers. Pointers are exactly AW bits wide so they wrap from
  // DEPTH_P-1 back to 0 on their own; the separate count register tells the
  // full and empty cases apart when the pointers are equal.
  logic [WIDTH_P-1:0] mem_q [DEPTH_P];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q,  count_d;

  logic enq;         // input-side handshake completes
  logic deq;         // output-side handshake completes
  logic bypass_hit;  // incoming word is being shown directly on the output
  logic wr_en;       // word actually written into storage
  logic rd_en;       // head entry actually retired from storage

  // -------------------------------------------------------------------------
  // Handshake and output decode
  // -------------------------------------------------------------------------
  always_comb begin
    ready_o = reset_i & (count_q != FULL_C);
    enq     = valid_i & ready_o & ~mis_predict;

`ifdef FE_QUEUE_BYPASS_EN
    // Empty queue: forward the arriving word combinationally so an idle
    // queue adds no latency.
    bypass_hit = enq & (count_q == '0);
    valid_o    = reset_i & ((count_q != '0) | bypass_hit);
    data_o     = bypass_hit ? data_i : mem_q[rd_ptr_q];
`else
    bypass_hit = 1'b0;
    valid_o    = reset_i & (count_q != '0);
    data_o     = mem_q[rd_ptr_q];
`endif

    deq = valid_o & ready_i & ~mis_predict;

    // A bypassed word that is consumed in the same cycle never touches
    // storage. A bypassed word that is not consumed is written normally.
    // When bypassing, storage is empty so nothing is retired from it.
    wr_en = enq & ~(bypass_hit & ready_i);
    rd_en = deq & ~bypass_hit;

    // Hide the count while reset is held so the consumer sees a clean zero.
    count_o = reset_i ? count_q : '0;
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(rd_en);
    count_d  = count_q + CW'(wr_en) - CW'(rd_en);
    if (mis_predict) begin
      // Flush: everything in flight is wrong-path. enq/deq are already
      // suppressed, so nothing is written or retired this cycle.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // -------------------------------------------------------------------------
  // State registers (reset has priority over the flush)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage is never reset; occupancy alone decides what is valid.
  // The payload (including any branch speculation fields) is opaque here.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // -------------------------------------------------------------------------
  // Simulation checks on internal consistency
  // -------------------------------------------------------------------------
  always @(posedge clk_i) begin
    if (reset_i) begin
      assert (!(wr_en && (count_q == FULL_C)));
      assert (!(rd_en && (count_q == '0)));
      assert (count_q <= FULL_C);
      // Low bits of the count equal the pointer distance; the extra bit
      // distinguishes full from empty when the pointers coincide.
      assert (count_q[AW-1:0] == AW'(wr_ptr_q - rd_ptr_q));
    end
  end

endmodule

// File: tb/tb_fe_dispatch_queue.sv
// ---------------------------------------------------------------------------
// tb_fe_dispatch_queue
//
// Directed and randomized stimulus for fe_dispatch_queue. Expected outputs
// come from a queue-based reference model of the FIFO behaviour: the model
// holds the words that should currently be inside the dispatch queue, in
// order, and derives ready/valid/data/count from that list every cycle.
// Honours FE_QUEUE_BYPASS_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_fe_dispatch_queue;

  localparam int DEPTH = 8;
  localparam int W     = 64;
  localparam int CW    = $clog2(DEPTH) + 1;

  // -------------------------------------------------------------------------
  // Clock / reset / DUT
  // -------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          flush = 1'b0;
  logic          valid_in = 1'b0;
  logic [W-1:0]  data_in = '0;
  logic          ready_out;
  logic          valid_out;
  logic [W-1:0]  data_out;
  logic          ready_in = 1'b0;
  logic [CW-1:0] count_out;

  always #5 clk = ~clk;

  fe_dispatch_queue #(
    .DEPTH_P (DEPTH),
    .WIDTH_P (W)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_n),
    .mis_predict (flush),
    .valid_i     (valid_in),
    .data_i      (data_in),
    .ready_o     (ready_out),
    .valid_o     (valid_out),
    .data_o      (data_out),
    .ready_i     (ready_in),
    .count_o     (count_out)
  );

  // -------------------------------------------------------------------------
  // Scoreboard state
  // -------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];   // words that should be inside the queue, head first
  int total = 0;
  int bad   = 0;

  // -------------------------------------------------------------------------
  // Driver + checker: apply one cycle of inputs, check outputs before the
  // rising edge, then advance the reference model across the edge.
  // -------------------------------------------------------------------------
  task automatic step(input logic rst_n, input logic v, input logic [W-1:0] d,
                      input logic r, input logic mp);
    logic          exp_valid;
    logic          exp_ready;
    logic [W-1:0]  exp_data;
    logic [CW-1:0] exp_count;
    logic          acc;
    logic          take;
    int            n;

    @(negedge clk);
    reset_n  = rst_n;
    valid_in = v;
    data_in  = d;
    ready_in = r;
    flush    = mp;
    #1;

    n         = exp_q.size();
    exp_data  = '0;
    if (!rst_n) begin
      exp_valid = 1'b0;
      exp_ready = 1'b0;
      exp_count = '0;
      acc       = 1'b0;
      take      = 1'b0;
    end else begin
      exp_ready = (n != DEPTH);
      exp_count = CW'(n);
      acc       = v & exp_ready & ~mp;
      exp_valid = (n != 0);
      if (n != 0) exp_data = exp_q[0];
`ifdef FE_QUEUE_BYPASS_EN
      if (n == 0 && acc) begin
        exp_valid = 1'b1;
        exp_data  = d;
      end
`endif
      take = exp_valid & r & ~mp;
    end

    total++;
    assert (ready_out === exp_ready)
      else begin bad++; $error("FAIL ready_o: got %b want %b", ready_out, exp_ready); end
    total++;
    assert (valid_out === exp_valid)
      else begin bad++; $error("FAIL valid_o: got %b want %b", valid_out, exp_valid); end
    total++;
    assert (count_out === exp_count)
      else begin bad++; $error("FAIL count_o: got %0d want %0d", count_out, exp_count); end
    if (exp_valid) begin
      total++;
      assert (data_out === exp_data)
        else begin bad++; $error("FAIL data_o: got %h want %h", data_out, exp_data); end
    end

    @(posedge clk);
    if (!rst_n || mp) begin
      exp_q.delete();
    end else begin
      if (take && n != 0) void'(exp_q.pop_front());
      // A word taken straight through an empty queue never enters it.
      if (acc && !(n == 0 && take)) exp_q.push_back(d);
    end
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    // 1: reset held two cycles with valid asserted, then released
    step(1'b0, 1'b1, 64'h99, 1'b0, 1'b0);
    step(1'b0, 1'b1, 64'h99, 1'b0, 1'b0);
    step(1'b1, 1'b0, 64'h0, 1'b0, 1'b0);

    // 2: fill to full with dispatch stalled, hold a 9th word, then drain
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, W'(64'h10 + i), 1'b0, 1'b0);
    step(1'b1, 1'b1, 64'h18, 1'b0, 1'b0);
    step(1'b1, 1'b1, 64'h18, 1'b1, 1'b0);   // full: dequeue only, 0x18 refused
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 64'h0, 1'b1, 1'b0);

    // 3: pointer wrap with dispatch always ready
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, W'(64'h60 + i), 1'b1, 1'b0);
    step(1'b1, 1'b0, 64'h0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, W'(64'hA0 + i), 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 64'h0, 1'b1, 1'b0);

    // 4: steady state at occupancy 4 with simultaneous enq and deq
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, W'(64'h40 + i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, W'(64'hB0 + i), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 64'h0, 1'b1, 1'b0);

    // 5: flush at occupancy 5 while a word is offered
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, W'(64'h50 + i), 1'b0, 1'b0);
    step(1'b1, 1'b1, 64'h55, 1'b1, 1'b1);
    step(1'b1, 1'b0, 64'h0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 64'h0, 1'b1, 1'b0);

    // 6: single word through an empty queue
    step(1'b1, 1'b1, 64'h3C, 1'b1, 1'b0);
    step(1'b1, 1'b0, 64'h0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 64'h0, 1'b1, 1'b0);

    // Reset in the middle of a non-empty queue
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, W'(64'h70 + i), 1'b0, 1'b0);
    step(1'b0, 1'b1, 64'h77, 1'b1, 1'b1);
    step(1'b1, 1'b0, 64'h0, 1'b1, 1'b0);

    // Randomized traffic: phases bias dispatch readiness so the queue
    // visits both full and empty regularly.
    for (int i = 0; i < 600; i++) begin
      logic          rr;
      logic          vv;
      logic          mm;
      logic          rs;
      logic [W-1:0]  dd;
      dd = {$urandom, $urandom};
      vv = ($urandom_range(0, 3) != 0);
      if ((i / 40) % 2 == 0) rr = ($urandom_range(0, 3) == 0);
      else                   rr = ($urandom_range(0, 3) != 0);
      mm = ($urandom_range(0, 29) == 0);
      rs = ($urandom_range(0, 79) != 0);
      step(rs, vv, dd, rr, mm);
    end
    for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 1'b0, 64'h0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
